// File: rtl/control_unit.sv
// Multi-cycle control FSM for the accumulator CPU: sequences fetch, decode,
// optional indirect-address load and execute, and decodes all datapath controls.
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] IReg_Data_Out,
   input  logic [7:0] Acc_Data_Out,
   input  logic       Mem_Ready,
   output logic       IReg_En,
   output logic       PC_En,
   output logic       IAR_En,
   output logic       Acc_En,
   output logic       IReg_Buffer_Sel,
   output logic       PC_Buffer_Sel,
   output logic       IAR_Buffer_Sel,
   output logic       Acc_Buffer_Sel,
   output logic       Mux_PC_Add_Sel,
   output logic       Mux_PC_In_Sel,
   output logic [1:0] Mux_Acc_In_Sel,
   output logic [1:0] ALU_Sel,
   output logic       Mem_Rd,
   output logic       Mem_Wr,
   output logic       Halted
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] INDIR  = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   logic [2:0] state, state_nxt;
   logic [3:0] opcode;
   logic       via_iar;
   logic       operand_unused;

   assign opcode         = IReg_Data_Out[7:4];
   assign via_iar        = (opcode == 4'hA) || (opcode == 4'hB);
   assign operand_unused = ^IReg_Data_Out[3:0];

   always_ff @(posedge clk) begin
      if (!rst)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   // Outputs stay at their zero defaults whenever reset is asserted.
   always_comb begin
      state_nxt       = state;
      IReg_En         = 1'b0;
      PC_En           = 1'b0;
      IAR_En          = 1'b0;
      Acc_En          = 1'b0;
      IReg_Buffer_Sel = 1'b0;
      PC_Buffer_Sel   = 1'b0;
      IAR_Buffer_Sel  = 1'b0;
      Acc_Buffer_Sel  = 1'b0;
      Mux_PC_Add_Sel  = 1'b0;
      Mux_PC_In_Sel   = 1'b0;
      Mux_Acc_In_Sel  = 2'b00;
      ALU_Sel         = 2'b00;
      Mem_Rd          = 1'b0;
      Mem_Wr          = 1'b0;
      Halted          = 1'b0;
      if (rst) begin
         case (state)
            FETCH: begin
               PC_Buffer_Sel = 1'b1;
               Mem_Rd        = 1'b1;
               if (Mem_Ready) begin
                  IReg_En   = 1'b1;
                  state_nxt = DECODE;
               end
            end
            DECODE: begin
               PC_En          = 1'b1;
               Mux_PC_Add_Sel = 1'b1;
               Mux_PC_In_Sel  = 1'b1;
               if (via_iar)
                  state_nxt = INDIR;
               else if (opcode == 4'hF)
                  state_nxt = HALT;
               else
                  state_nxt = EXEC;
            end
            INDIR: begin
               IReg_Buffer_Sel = 1'b1;
               Mem_Rd          = 1'b1;
               if (Mem_Ready) begin
                  IAR_En    = 1'b1;
                  state_nxt = EXEC;
               end
            end
            EXEC: begin
               state_nxt = FETCH;
               case (opcode)
                  4'h1: begin
                     Acc_En         = 1'b1;
                     Mux_Acc_In_Sel = 2'b01;
                  end
                  // Loads and ALU ops share one read path; bit 2 picks the ALU as source.
                  4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA: begin
                     IReg_Buffer_Sel = !via_iar;
                     IAR_Buffer_Sel  = via_iar;
                     Mem_Rd          = 1'b1;
                     if (Mem_Ready) begin
                        Acc_En         = 1'b1;
                        Mux_Acc_In_Sel = opcode[2] ? 2'b11 : 2'b10;
                        ALU_Sel        = opcode[2] ? opcode[1:0] : 2'b00;
                     end else begin
                        state_nxt = EXEC;
                     end
                  end
                  4'h3, 4'hB: begin
                     IReg_Buffer_Sel = !via_iar;
                     IAR_Buffer_Sel  = via_iar;
                     Acc_Buffer_Sel  = 1'b1;
                     Mem_Wr          = 1'b1;
                     if (!Mem_Ready)
                        state_nxt = EXEC;
                  end
                  4'h8: begin
                     PC_En         = 1'b1;
                     Mux_PC_In_Sel = 1'b1;
                  end
                  4'h9: begin
                     if (Acc_Data_Out == 8'h00) begin
                        PC_En         = 1'b1;
                        Mux_PC_In_Sel = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            HALT: begin
               Halted = 1'b1;
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: a step-plan reference model
// predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_control_unit;

   logic       clk = 1'b1;
   logic       rst;
   logic [7:0] IReg_Data_Out;
   logic [7:0] Acc_Data_Out;
   logic       Mem_Ready;
   logic       IReg_En, PC_En, IAR_En, Acc_En;
   logic       IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel;
   logic       Mux_PC_Add_Sel, Mux_PC_In_Sel;
   logic [1:0] Mux_Acc_In_Sel, ALU_Sel;
   logic       Mem_Rd, Mem_Wr, Halted;

   control_unit dut (
      .clk(clk), .rst(rst),
      .IReg_Data_Out(IReg_Data_Out), .Acc_Data_Out(Acc_Data_Out), .Mem_Ready(Mem_Ready),
      .IReg_En(IReg_En), .PC_En(PC_En), .IAR_En(IAR_En), .Acc_En(Acc_En),
      .IReg_Buffer_Sel(IReg_Buffer_Sel), .PC_Buffer_Sel(PC_Buffer_Sel),
      .IAR_Buffer_Sel(IAR_Buffer_Sel), .Acc_Buffer_Sel(Acc_Buffer_Sel),
      .Mux_PC_Add_Sel(Mux_PC_Add_Sel), .Mux_PC_In_Sel(Mux_PC_In_Sel),
      .Mux_Acc_In_Sel(Mux_Acc_In_Sel), .ALU_Sel(ALU_Sel),
      .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Halted(Halted)
   );

   always #5 clk = ~clk;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_INDIR  = 2;
   localparam int P_EXEC   = 3;
   localparam int P_HALT   = 4;

   int          plan[$];
   logic [16:0] exp_q[$];
   logic [7:0]  instr;
   logic [7:0]  favourites[5] = '{8'h15, 8'h43, 8'h92, 8'hB7, 8'hF0};
   int          halt_cnt, halt_len;
   int          checks = 0;
   int          errors = 0;
   int          cyc_mon = 0;

   function automatic bit is_load(input logic [3:0] op);
      return (op == 4'h2) || (op >= 4'h4 && op <= 4'h7) || (op == 4'hA);
   endfunction

   function automatic bit is_store(input logic [3:0] op);
      return (op == 4'h3) || (op == 4'hB);
   endfunction

   // Expected output vector for one cycle, from the current step of the instruction.
   function automatic logic [16:0] ref_outs(input int step, input logic [7:0] ins,
                                            input logic [7:0] acc, input logic rdy,
                                            input logic rst_n);
      logic       ireg_en, pc_en, iar_en, acc_en, ib, pb, ab, accb, add1, pcin, rd, wr, hlt;
      logic [1:0] src, alu;
      logic [3:0] op;
      {ireg_en, pc_en, iar_en, acc_en, ib, pb, ab, accb, add1, pcin, rd, wr, hlt} = '0;
      src = 2'b00;
      alu = 2'b00;
      op  = ins[7:4];
      if (rst_n) begin
         if (step == P_FETCH) begin
            pb = 1; rd = 1; ireg_en = rdy;
         end else if (step == P_DECODE) begin
            pc_en = 1; add1 = 1; pcin = 1;
         end else if (step == P_INDIR) begin
            ib = 1; rd = 1; iar_en = rdy;
         end else if (step == P_HALT) begin
            hlt = 1;
         end else begin
            if (op == 4'h1) begin
               acc_en = 1; src = 2'b01;
            end else if (is_load(op) || is_store(op)) begin
               ab = (op >= 4'hA);
               ib = !ab;
               if (is_load(op)) rd = 1;
               else begin accb = 1; wr = 1; end
               if (is_load(op) && rdy) begin
                  acc_en = 1;
                  if (op >= 4'h4 && op <= 4'h7) begin
                     src = 2'b11;
                     alu = 2'(op - 4'd4);
                  end else begin
                     src = 2'b10;
                  end
               end
            end else if (op == 4'h8 || (op == 4'h9 && acc == 8'h00)) begin
               pc_en = 1; add1 = 0; pcin = 1;
            end
         end
      end
      return {ireg_en, pc_en, iar_en, acc_en, ib, pb, ab, accb, add1, pcin, src, alu, rd, wr, hlt};
   endfunction

   task automatic start_instr();
      plan.push_back(P_FETCH);
      if ($urandom_range(0, 3) == 0) instr = favourites[$urandom_range(0, 4)];
      else instr = 8'($urandom);
   endtask

   // Advance the step plan across one clock edge.
   task automatic model_step(input logic r, input logic rdy);
      int  head;
      bit  done;
      logic [3:0] op;
      if (!r) begin
         plan.delete();
         start_instr();
         return;
      end
      head = plan[0];
      op   = instr[7:4];
      case (head)
         P_FETCH:  done = rdy;
         P_DECODE: done = 1;
         P_INDIR:  done = rdy;
         P_EXEC:   done = (is_load(op) || is_store(op)) ? rdy : 1'b1;
         default:  done = 0;
      endcase
      if (done) begin
         void'(plan.pop_front());
         if (head == P_FETCH) plan.push_back(P_DECODE);
         if (head == P_DECODE) begin
            if (op == 4'hA || op == 4'hB) begin
               plan.push_back(P_INDIR);
               plan.push_back(P_EXEC);
            end else if (op == 4'hF) begin
               plan.push_back(P_HALT);
               halt_cnt = 0;
               halt_len = $urandom_range(1, 25);
            end else begin
               plan.push_back(P_EXEC);
            end
         end
         if (plan.size() == 0) start_instr();
      end
   endtask

   initial begin
      logic       r, rdy;
      logic [7:0] acc;
      rst = 1'b0; IReg_Data_Out = '0; Acc_Data_Out = '0; Mem_Ready = 1'b0;
      halt_cnt = 0; halt_len = 1;
      start_instr();
      for (int c = 0; c < 4000; c++) begin
         r = 1'b1;
         if (c < 3) r = 1'b0;
         else if ($urandom_range(0, 99) < 2) r = 1'b0;
         if (plan[0] == P_HALT) begin
            halt_cnt++;
            if (halt_cnt > halt_len) r = 1'b0;
         end
         rdy = ($urandom_range(0, 9) < 6);
         acc = ($urandom_range(0, 9) < 4) ? 8'h00 : 8'($urandom);
         rst = r; Mem_Ready = rdy; Acc_Data_Out = acc; IReg_Data_Out = instr;
         exp_q.push_back(ref_outs(plan[0], instr, acc, rdy, r));
         model_step(r, rdy);
         @(posedge clk);
         #1;
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   always @(negedge clk) begin
      logic [16:0] exp_v, act_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {IReg_En, PC_En, IAR_En, Acc_En, IReg_Buffer_Sel, PC_Buffer_Sel,
                  IAR_Buffer_Sel, Acc_Buffer_Sel, Mux_PC_Add_Sel, Mux_PC_In_Sel,
                  Mux_Acc_In_Sel, ALU_Sel, Mem_Rd, Mem_Wr, Halted};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %b required %b (rst=%b ireg=%h acc=%h rdy=%b)",
                     cyc_mon, act_v, exp_v, rst, IReg_Data_Out, Acc_Data_Out, Mem_Ready);
         end
         checks++;
         if (!$onehot0({IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel})) begin
            errors++;
            $display("FAIL bus_sel cycle %0d: got %b%b%b required at most one high",
                     cyc_mon, IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel);
         end
         checks++;
         if (Mem_Rd && Mem_Wr) begin
            errors++;
            $display("FAIL strobes cycle %0d: got rd=%b wr=%b required not both", cyc_mon, Mem_Rd, Mem_Wr);
         end
         cyc_mon++;
      end
   end

endmodule
